snes_bus_drive: RTL and testbench
=================================

Name: snes_bus_drive

Overview:
- Initiator/driver side of the SNES B-bus (PA) access protocol; counterpart of the PA change-detect synchronizer.
- Takes single-beat read/write requests in the 40 MHz domain and drives PA, PARD_n, PAWR_n and the data bus with programmable setup, strobe and hold phases.
- Holds the address stable long enough for a 3-stage change detector on the far end to settle.
- Used for bench stimulus and for on-board B-bus register pokes.

Parameters:
SETUP_CYC, 4, cycles PA is stable before strobe (1..15)
STROBE_CYC, 6, cycles PARD_n/PAWR_n asserted (1..15)
HOLD_CYC, 4, cycles PA/D held after strobe release (1..15)
PARK_ADDR, 8'hFF, idle address used by the optional park phase

Ports:
clk  in  1  40 MHz clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1=write, 0=read
req_addr  in  8  B-bus address
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  8  read data (valid with rsp_valid on reads)
busy  out  1  state != IDLE
PA  out  8  B-bus address
PARD_n  out  1  read strobe, active low
PAWR_n  out  1  write strobe, active low
D_out  out  8  data to bus
D_oe  out  1  data output enable
D_in  in  8  raw async data from bus

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: PA=0, PARD_n=1, PAWR_n=1, D_out=0, D_oe=0, rsp_valid=0, rsp_rdata=0, state=IDLE, counter=0. Strobes deassert immediately on reset assertion, including mid-access. No response is produced for an aborted access.
- All bus outputs are registered; no combinational path from req_* to bus pins.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE (PARK inserted with the optional feature). A 4-bit down-counter is loaded on every state entry.
- IDLE:
  - req_ready=1.
  - On accept (cycle t0), latch write/addr/wdata. PA<=req_addr; D_out<=req_wdata and D_oe<=1 if write. Enter SETUP with counter=SETUP_CYC.
- SETUP: strobes high. When the counter expires, enter STROBE; the matching strobe goes low from cycle t0+1+SETUP_CYC.
- STROBE:
  - Exactly STROBE_CYC cycles low: PAWR_n for writes, PARD_n for reads. Never both.
  - D_in passes through a 2-flop synchronizer every cycle.
  - On the edge that releases the strobe, a read captures the second sync stage into rsp_rdata.
- HOLD: HOLD_CYC cycles; PA, D_out and D_oe unchanged.
- Completion:
  - On exit from HOLD, D_oe<=0 and the block returns to IDLE.
  - rsp_valid=1 for exactly the first IDLE cycle, at t0+1+SETUP_CYC+STROBE_CYC+HOLD_CYC with defaults t0+15.
  - req_ready is also 1 in that cycle, so back-to-back accepts are allowed.
- rsp_rdata is unchanged on writes.
- PA keeps its last value while idle; it never changes outside an accept or the park phase.
- req_valid while busy is ignored and never dropped. The requester holds it; it is accepted on the next IDLE cycle.
- Parameter value 0 is illegal; behaviour is undefined.

Optional Feature:
SNES_BUS_DRIVE_PARK_EN
- Defined:
  - After HOLD, enter PARK for SETUP_CYC cycles with PA=PARK_ADDR, strobes high, D_oe=0. Then go to IDLE.
  - rsp_valid fires on IDLE entry after PARK.
  - Guarantees every access produces an observable PA change, even for repeated addresses.
  - Requests whose addr equals PARK_ADDR are still legal.
- Undefined:
  - No PARK state.
  - Repeated same-address accesses leave PA constant between accesses.

Test Plan:
1. Write: accept addr 0x21, wdata 0x5A, write=1 at t0 -> PA=0x21 from t0+1; D_oe=1, D_out=0x5A t0+1..t0+14; PAWR_n low t0+5..t0+10; PARD_n always 1; rsp_valid pulse at t0+15.
2. Read: addr 0x18, D_in held at 0xC3 -> PARD_n low t0+5..t0+10; D_oe=0 throughout; rsp_valid at t0+15 with rsp_rdata=0xC3.
3. Back-to-back: two writes to 0x21 with req_valid held -> second accept in the rsp_valid cycle. Without park, PA stays 0x21. With SNES_BUS_DRIVE_PARK_EN, PA=0xFF for 4 cycles between accesses and the second accept is delayed by 4 cycles.
4. Busy stall: req_valid asserted at t0+3 while busy -> req_ready=0 until t0+15; request accepted at t0+15; no request lost or duplicated.
5. Reset mid-strobe: assert rst_n low at t0+7 of a write -> PAWR_n=1, D_oe=0, PA=0 immediately; no rsp_valid. After release, the block is in IDLE with req_ready=1.
6. Timing params: SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1 read of addr 0x40 -> strobe low exactly one cycle at t0+2; rsp_valid at t0+4.

Source files
------------

// File: rtl/snes_bus_drive.sv
// Initiator side of the SNES B-bus (PA) access: setup / strobe / hold sequencing of PA, PARD_n, PAWR_n and D.
// Optional park phase (PA driven to PARK_ADDR after every access) is enabled with `define SNES_BUS_DRIVE_PARK_EN.
module snes_bus_drive #(
    parameter int         SETUP_CYC  = 4,
    parameter int         STROBE_CYC = 6,
    parameter int         HOLD_CYC   = 4,
    parameter logic [7:0] PARK_ADDR  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic [7:0] PA,
    output logic       PARD_n,
    output logic       PAWR_n,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in
);

    localparam logic [3:0] SETUP_L  = 4'(SETUP_CYC);
    localparam logic [3:0] STROBE_L = 4'(STROBE_CYC);
    localparam logic [3:0] HOLD_L   = 4'(HOLD_CYC);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        PARK   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic [7:0] pa_q, pa_d;
    logic [7:0] dout_q, dout_d;
    logic       doe_q, doe_d;
    logic       pard_n_q, pard_n_d;
    logic       pawr_n_q, pawr_n_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] sync1_q, sync2_q;

    // Each state lasts exactly its loaded count; leaving on cnt_q==1 keeps
    // strobe/pin registers aligned with the state they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        pa_d        = pa_q;
        dout_d      = dout_q;
        doe_d       = doe_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        pard_n_d    = 1'b1;
        pawr_n_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    pa_d    = req_addr;
                    if (req_write) begin
                        dout_d = req_wdata;
                        doe_d  = 1'b1;
                    end
                    state_d = SETUP;
                    cnt_d   = SETUP_L;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd1) begin
                    state_d  = STROBE;
                    cnt_d    = STROBE_L;
                    pawr_n_d = ~write_q;
                    pard_n_d = write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd1) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_L;
                    if (!write_q) begin
                        rdata_d = sync2_q;
                    end
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    pawr_n_d = ~write_q;
                    pard_n_d = write_q;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd1) begin
                    doe_d = 1'b0;
`ifdef SNES_BUS_DRIVE_PARK_EN
                    state_d = PARK;
                    cnt_d   = SETUP_L;
                    pa_d    = PARK_ADDR;
`else
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                    rsp_valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            PARK: begin
`ifdef SNES_BUS_DRIVE_PARK_EN
                if (cnt_q == 4'd1) begin
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
`else
                state_d = IDLE;
                cnt_d   = 4'd0;
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            pa_q        <= 8'h00;
            dout_q      <= 8'h00;
            doe_q       <= 1'b0;
            pard_n_q    <= 1'b1;
            pawr_n_q    <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
            sync1_q     <= 8'h00;
            sync2_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            pa_q        <= pa_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            pard_n_q    <= pard_n_d;
            pawr_n_q    <= pawr_n_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            sync1_q     <= D_in;
            sync2_q     <= sync1_q;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign PA        = pa_q;
    assign PARD_n    = pard_n_q;
    assign PAWR_n    = pawr_n_q;
    assign D_out     = dout_q;
    assign D_oe      = doe_q;

endmodule

// File: tb/tb_snes_bus_drive.sv
// Self-checking bench for snes_bus_drive: default-timing instance plus a 1/1/1 timing instance.
// Expected read data flows through a scoreboard queue pushed on accept and popped on rsp_valid.
`timescale 1ns/1ps
module tb_snes_bus_drive;

    localparam int S  = 4;
    localparam int ST = 6;
    localparam int H  = 4;
`ifdef SNES_BUS_DRIVE_PARK_EN
    localparam int  LAT    = 1 + S + ST + H + S;
    localparam int  LATF   = 5;
    localparam bit  PARKED = 1'b1;
`else
    localparam int  LAT    = 1 + S + ST + H;
    localparam int  LATF   = 4;
    localparam bit  PARKED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [7:0] req_addr = 8'h00, req_wdata = 8'h00, D_in = 8'h00;
    logic       req_ready, rsp_valid, busy, PARD_n, PAWR_n, D_oe;
    logic [7:0] rsp_rdata, PA, D_out;

    logic       f_req_valid = 1'b0, f_req_write = 1'b0;
    logic [7:0] f_req_addr = 8'h00, f_req_wdata = 8'h00, f_D_in = 8'h00;
    logic       f_req_ready, f_rsp_valid, f_busy, f_PARD_n, f_PAWR_n, f_D_oe;
    logic [7:0] f_rsp_rdata, f_PA, f_D_out;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fexp_q[$];
    logic [7:0] model_rdata = 8'h00;
    logic [7:0] exp_data;

    always #5 clk = ~clk;

    snes_bus_drive dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .PA(PA), .PARD_n(PARD_n), .PAWR_n(PAWR_n),
        .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
    );

    snes_bus_drive #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_fast (
        .clk(clk), .rst_n(rst_n),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .busy(f_busy),
        .PA(f_PA), .PARD_n(f_PARD_n), .PAWR_n(f_PAWR_n),
        .D_out(f_D_out), .D_oe(f_D_oe), .D_in(f_D_in)
    );

    task automatic test_reset();
        logic [22:0] got, want;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        got  = {PA, PARD_n, PAWR_n, D_out, D_oe, rsp_valid, busy, req_ready};
        want = {8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL reset_pins got %h want %h", got, want);
        end
        checks++;
        if (rsp_rdata !== 8'h00 || f_rsp_rdata !== 8'h00 || f_PA !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_rdata got %h/%h/%h want 00/00/00", rsp_rdata, f_rsp_rdata, f_PA);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One complete access on the default instance with per-cycle pin checks.
    task automatic test_single_access(input logic wr, input logic [7:0] addr,
                                      input logic [7:0] wdata, input logic [7:0] din);
        logic [12:0] got, want;
        logic        strb;
        D_in = din;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_ready_t0 got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        if (wr) exp_q.push_back(model_rdata);
        else begin
            exp_q.push_back(din);
            model_rdata = din;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            strb = (c >= 1 + S) && (c <= S + ST);
            want = {((PARKED && c > S + ST + H) ? 8'hFF : addr),
                    ~(~wr & strb), ~(wr & strb),
                    (wr && c <= S + ST + H), (c == LAT), (c < LAT)};
            got  = {PA, PARD_n, PAWR_n, D_oe, rsp_valid, busy};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL single_pins wr=%b c=%0d got %h want %h", wr, c, got, want);
            end
            if (wr && c <= S + ST + H) begin
                checks++;
                if (D_out !== wdata) begin
                    errors++;
                    $display("[TB] FAIL single_dout c=%0d got %h want %h", c, D_out, wdata);
                end
            end
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL single_rsp_unexpected c=%0d got %h want none", c, rsp_rdata);
                end else begin
                    exp_data = exp_q.pop_front();
                    if (rsp_rdata !== exp_data) begin
                        errors++;
                        $display("[TB] FAIL single_rdata c=%0d got %h want %h", c, rsp_rdata, exp_data);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] got, want;
        logic [7:0]  wd;
        int          k;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h21; req_wdata = 8'h5A;
        exp_q.push_back(model_rdata);
        for (int c = 1; c <= 2 * LAT; c++) begin
            @(negedge clk);
            if (c == 1) req_wdata = 8'h3C;
            k  = c % LAT;
            wd = (c < LAT) ? 8'h5A : 8'h3C;
            want = {((PARKED && (k == 0 || k > S + ST + H)) ? 8'hFF : 8'h21),
                    1'b1, ~(k >= 1 + S && k <= S + ST),
                    (k >= 1 && k <= S + ST + H), (k == 0), (k != 0)};
            got  = {PA, PARD_n, PAWR_n, D_oe, rsp_valid, busy};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL b2b_pins c=%0d got %h want %h", c, got, want);
            end
            checks++;
            if (req_ready !== (k == 0)) begin
                errors++;
                $display("[TB] FAIL b2b_ready c=%0d got %b want %b", c, req_ready, (k == 0));
            end
            if (D_oe && D_out !== wd) begin
                checks++;
                errors++;
                $display("[TB] FAIL b2b_dout c=%0d got %h want %h", c, D_out, wd);
            end
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_rsp_unexpected c=%0d got %h want none", c, rsp_rdata);
                end else begin
                    exp_data = exp_q.pop_front();
                    if (rsp_rdata !== exp_data) begin
                        errors++;
                        $display("[TB] FAIL b2b_rdata c=%0d got %h want %h", c, rsp_rdata, exp_data);
                    end
                end
            end
            if (c == LAT) begin
                exp_q.push_back(model_rdata);
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_busy_stall();
        D_in = 8'h96;
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h55;
        exp_q.push_back(8'h96);
        model_rdata = 8'h96;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 2 * LAT + 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== (c == LAT || c >= 2 * LAT)) begin
                errors++;
                $display("[TB] FAIL stall_ready c=%0d got %b want %b", c, req_ready, (c == LAT || c >= 2 * LAT));
            end
            checks++;
            if (rsp_valid !== (c == LAT || c == 2 * LAT)) begin
                errors++;
                $display("[TB] FAIL stall_rsp_valid c=%0d got %b want %b", c, rsp_valid, (c == LAT || c == 2 * LAT));
            end
            if (rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stall_rsp_unexpected c=%0d got %h want none", c, rsp_rdata);
                end else begin
                    exp_data = exp_q.pop_front();
                    if (rsp_rdata !== exp_data) begin
                        errors++;
                        $display("[TB] FAIL stall_rdata c=%0d got %h want %h", c, rsp_rdata, exp_data);
                    end
                end
            end
            if (c == LAT + 1) begin
                checks++;
                if (PA !== 8'h33 || D_oe !== 1'b1 || D_out !== 8'h77) begin
                    errors++;
                    $display("[TB] FAIL stall_second got %h/%b/%h want 33/1/77", PA, D_oe, D_out);
                end
            end
            if (c == 3) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h33; req_wdata = 8'h77;
            end
            if (c == LAT) begin
                exp_q.push_back(model_rdata);
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h21; req_wdata = 8'hA5;
        exp_q.push_back(model_rdata);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (PAWR_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_pre_strobe got %b want 0", PAWR_n);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({PAWR_n, PARD_n, D_oe, PA, rsp_valid} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL abort_pins got %b%b%b %h %b want 110 00 0", PAWR_n, PARD_n, D_oe, PA, rsp_valid);
        end
        exp_q.delete();
        model_rdata = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle got ready=%b busy=%b want 1/0", req_ready, busy);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_no_rsp c=%0d got %b want 0", c, rsp_valid);
            end
        end
    endtask

    task automatic test_timing_params();
        f_D_in = 8'h5E;
        repeat (3) @(negedge clk);
        f_req_valid = 1'b1; f_req_write = 1'b0; f_req_addr = 8'h40;
        fexp_q.push_back(8'h5E);
        @(posedge clk);
        #1 f_req_valid = 1'b0;
        for (int c = 1; c <= LATF + 1; c++) begin
            @(negedge clk);
            checks++;
            if ({f_PARD_n, f_PAWR_n, f_D_oe, f_rsp_valid} !== {(c != 2), 1'b1, 1'b0, (c == LATF)}) begin
                errors++;
                $display("[TB] FAIL fast_pins c=%0d got %b%b%b%b want %b110%b", c, f_PARD_n, f_PAWR_n,
                         f_D_oe, f_rsp_valid, (c != 2), (c == LATF));
            end
            if (c <= 3) begin
                checks++;
                if (f_PA !== 8'h40) begin
                    errors++;
                    $display("[TB] FAIL fast_pa c=%0d got %h want 40", c, f_PA);
                end
            end
            if (f_rsp_valid) begin
                checks++;
                if (fexp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL fast_rsp_unexpected c=%0d got %h want none", c, f_rsp_rdata);
                end else begin
                    exp_data = fexp_q.pop_front();
                    if (f_rsp_rdata !== exp_data) begin
                        errors++;
                        $display("[TB] FAIL fast_rdata c=%0d got %h want %h", c, f_rsp_rdata, exp_data);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_access(1'b1, 8'h21, 8'h5A, 8'h00);
        test_single_access(1'b0, 8'h18, 8'h00, 8'hC3);
        test_back_to_back();
        test_busy_stall();
        test_reset_mid_strobe();
        test_timing_params();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || fexp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d/%0d want 0/0", exp_q.size(), fexp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
